// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// Used by rr_priority_pick and rr_mux_arbiter.
package rr_arb_pkg;

    localparam int DEF_N_REQ  = 2;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Index width for n requesters, never below one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << w) < n) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority encoder: first set request after last_grant, wrapping modulo N_REQ.
// Purely combinational; the grant that was just served gets the lowest priority.
module rr_priority_pick
    import rr_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDX_W = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] winner,
    output logic             any_valid
);

    // Walk the ring from farthest to nearest so the nearest valid requester wins.
    always_comb begin
        winner    = last_grant;
        any_valid = |req;
        for (int k = N_REQ; k >= 1; k--) begin
            int idx;
            idx    = (int'(last_grant) + k) % N_REQ;
            winner = req[idx] ? IDX_W'(idx) : winner;
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one N:1 data mux over valid/ready, with a registered grant.
// Define RR_ARB_LOCK_EN to add req_last and hold the grant for a whole packet.
module rr_mux_arbiter
    import rr_arb_pkg::*;
#(
    parameter  int N_REQ  = DEF_N_REQ,
    parameter  int DATA_W = DEF_DATA_W,
    localparam int IDX_W  = clog2_min1(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
`ifdef RR_ARB_LOCK_EN
    input  logic [N_REQ-1:0]        req_last,
`endif
    output logic [N_REQ-1:0]        req_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    input  logic                    out_ready,
    output logic [IDX_W-1:0]        grant_idx,
    output logic                    busy
);

    state_t           state_r;
    logic [IDX_W-1:0] grant_idx_r;
    logic [IDX_W-1:0] last_grant_r;
    logic             busy_r;

    logic [IDX_W-1:0] pick_last_s;
    logic [IDX_W-1:0] winner_s;
    logic             any_valid_s;
    logic             cur_valid_s;
    logic             xfer_s;
    logic             rearb_s;
    logic             drop_hold_s;

    assign cur_valid_s = req_valid[grant_idx_r];
    assign xfer_s      = (state_r == GRANT) && cur_valid_s && out_ready;
    // On a transfer the current grant becomes last_grant, so arbitrate from it directly.
    assign pick_last_s = (state_r == GRANT) ? grant_idx_r : last_grant_r;

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (req_valid),
        .last_grant (pick_last_s),
        .winner     (winner_s),
        .any_valid  (any_valid_s)
    );

`ifdef RR_ARB_LOCK_EN
    logic pkt_r;

    assign rearb_s     = req_last[grant_idx_r];
    assign drop_hold_s = pkt_r;

    // Tracks whether the granted requester is part-way through a packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_r <= 1'b0;
        end else if (xfer_s) begin
            pkt_r <= ~req_last[grant_idx_r];
        end else begin
            pkt_r <= pkt_r;
        end
    end
`else
    assign rearb_s     = 1'b1;
    assign drop_hold_s = 1'b0;
`endif

    // Arbitration FSM with grant, last-grant and busy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            grant_idx_r  <= '0;
            last_grant_r <= IDX_W'(N_REQ - 1);
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_valid_s) begin
                        state_r     <= GRANT;
                        busy_r      <= 1'b1;
                        grant_idx_r <= winner_s;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                GRANT: begin
                    if (xfer_s) begin
                        last_grant_r <= grant_idx_r;
                        if (!rearb_s) begin
                            state_r <= GRANT;
                        end else if (any_valid_s) begin
                            grant_idx_r <= winner_s;
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else if (!cur_valid_s && !drop_hold_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= GRANT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Shared mux and ready steering from the registered grant.
    always_comb begin
        req_ready = '0;
        out_valid = 1'b0;
        out_data  = req_data[int'(grant_idx_r)*DATA_W +: DATA_W];
        if (state_r == GRANT) begin
            out_valid              = cur_valid_s;
            req_ready[grant_idx_r] = out_ready;
        end else begin
            out_valid = 1'b0;
        end
    end

    assign grant_idx = grant_idx_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (N_REQ=4) with a per-cycle reference model.
// Lock-mode scenario is compiled in when RR_ARB_LOCK_EN is defined.
module tb_rr_mux_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic [1:0]  grant_idx;
    logic        busy;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state: busy flag, current grant, last served, packet in progress.
    bit m_busy;
    int m_grant;
    int m_last;
    bit m_pkt;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.N_REQ(4), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
`ifdef RR_ARB_LOCK_EN
        .req_last  (req_last),
`endif
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // First valid requester after 'last' going round the ring of four.
    function automatic int pick(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (last + k) % 4;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit lock_mode();
`ifdef RR_ARB_LOCK_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        int w;
        bit xfer;
        if (rst) begin
            m_busy  <= 1'b0;
            m_grant <= 0;
            m_last  <= 3;
            m_pkt   <= 1'b0;
        end else if (!m_busy) begin
            w = pick(req_valid, m_last);
            if (w >= 0) begin
                m_busy  <= 1'b1;
                m_grant <= w;
            end
        end else begin
            xfer = req_valid[m_grant] && out_ready;
            if (xfer) begin
                m_last <= m_grant;
                if (lock_mode() && !req_last[m_grant]) begin
                    m_pkt <= 1'b1;
                end else begin
                    m_pkt <= 1'b0;
                    w = pick(req_valid, m_grant);
                    if (w >= 0) m_grant <= w;
                    else m_busy <= 1'b0;
                end
            end else if (!req_valid[m_grant] && !(lock_mode() && m_pkt)) begin
                m_busy <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] exp_rdy;
        bit exp_v;
        if (!rst) begin
            exp_v   = m_busy && req_valid[m_grant];
            exp_rdy = m_busy ? (4'(out_ready) << m_grant) : 4'b0000;
            check("model_busy", 32'(busy), 32'(m_busy));
            check("model_grant", 32'(grant_idx), 32'(m_grant));
            check("model_valid", 32'(out_valid), 32'(exp_v));
            check("model_ready", 32'(req_ready), 32'(exp_rdy));
            if (exp_v) check("model_data", 32'(out_data), 32'(req_data[m_grant*8 +: 8]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; req_valid = 4'b0000; req_data = 32'h0; req_last = 4'b1111; out_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_grant", 32'(grant_idx), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;

        // Single requester, one beat, then drop to IDLE.
        req_valid = 4'b0001; req_data[7:0] = 8'hA5; out_ready = 1'b1;
        cyc(); at_neg();
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_data", 32'(out_data), 32'hA5);
        check("single_ready", 32'(req_ready), 32'b0001);
        cyc(); req_valid = 4'b0000; at_neg();
        check("single_drop_valid", 32'(out_valid), 32'd0);
        cyc(); at_neg();
        check("single_idle_busy", 32'(busy), 32'd0);

        // Reset while granted with both requesters valid.
        req_valid = 4'b0011; req_data[15:0] = 16'h2211;
        cyc(); at_neg();
        check("pre_reset_grant", 32'(grant_idx), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_grant", 32'(grant_idx), 32'd0);
        check("midreset_valid", 32'(out_valid), 32'd0);
        check("midreset_ready", 32'(req_ready), 32'd0);
        cyc();
        #2 rst = 1'b0;

        // Fairness: alternating grants with no bubble.
        for (int i = 0; i < 4; i++) begin
            cyc(); at_neg();
            check("fair_grant", 32'(grant_idx), 32'(i % 2));
            check("fair_valid", 32'(out_valid), 32'd1);
            check("fair_data", 32'(out_data), (i % 2) ? 32'h22 : 32'h11);
        end
        req_valid = 4'b0000;
        cyc(); cyc();

        // Backpressure on requester 1.
        req_valid = 4'b0010; req_data[15:8] = 8'h3C; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(); at_neg();
            check("bp_grant", 32'(grant_idx), 32'd1);
            check("bp_data", 32'(out_data), 32'h3C);
            check("bp_ready", 32'(req_ready), 32'b0000);
        end
        cyc(); out_ready = 1'b1; at_neg();
        check("bp_release_ready", 32'(req_ready), 32'b0010);
        cyc(); req_valid = 4'b0000; at_neg();
        check("bp_after_valid", 32'(out_valid), 32'd0);
        cyc();

        // Wrap-around: requesters 3 and 0 alternate.
        req_valid = 4'b1000; req_data[31:24] = 8'hD3; req_data[7:0] = 8'hC0;
        cyc(); req_valid = 4'b1001; at_neg();
        check("wrap_grant_a", 32'(grant_idx), 32'd3);
        cyc(); at_neg();
        check("wrap_grant_b", 32'(grant_idx), 32'd0);
        cyc(); at_neg();
        check("wrap_grant_c", 32'(grant_idx), 32'd3);
        cyc(); at_neg();
        check("wrap_grant_d", 32'(grant_idx), 32'd0);
        req_valid = 4'b0000;
        cyc(); cyc();

`ifdef RR_ARB_LOCK_EN
        // Packet lock: requester 0 keeps the grant for three beats.
        req_valid = 4'b0011; req_last = 4'b0000;
        cyc(); at_neg();
        check("lock_beat1", 32'(grant_idx), 32'd0);
        cyc(); at_neg();
        check("lock_beat2", 32'(grant_idx), 32'd0);
        cyc(); req_last = 4'b0001; at_neg();
        check("lock_beat3", 32'(grant_idx), 32'd0);
        cyc(); req_last = 4'b1111; at_neg();
        check("lock_next_grant", 32'(grant_idx), 32'd1);
        req_valid = 4'b0000;
        cyc(); cyc();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
